// File: rtl/shift_reg_tap_if.sv
// Bundle of the shift_reg_tap control, input-entry and tap signals.
// The slave modport is the delay line itself; the master side is the user of the line.
interface shift_reg_tap_if #(
   parameter int DataWidth = 8,
   parameter int MaxDepth  = 4
);
   localparam int DelW = (MaxDepth < 1) ? 1 : $clog2(MaxDepth + 1);

   logic                 en_i;
   logic                 flush_i;
   logic [DelW-1:0]      delay_i;
   logic                 valid_i;
   logic [DataWidth-1:0] data_i;
   logic                 valid_o;
   logic [DataWidth-1:0] data_o;
   logic [DelW-1:0]      count_o;

   modport master (
      output en_i, flush_i, delay_i, valid_i, data_i,
      input  valid_o, data_o, count_o
   );

   modport slave (
      input  en_i, flush_i, delay_i, valid_i, data_i,
      output valid_o, data_o, count_o
   );
endinterface

// File: rtl/shift_reg_tap.sv
// Stallable, flushable delay line with per-stage valid bits and a runtime-selectable tap.
// MaxDepth=0 collapses the block to a wire from input to output.
module shift_reg_tap #(
   parameter int DataWidth = 8,
   parameter int MaxDepth  = 4
) (
   input logic           clk_i,
   input logic           rst_i,
   shift_reg_tap_if.slave bus
);
   localparam int DelW = (MaxDepth < 1) ? 1 : $clog2(MaxDepth + 1);

   if (MaxDepth == 0) begin : g_wire
      // No state at all; control inputs are deliberately left dangling into a sink.
      logic unused_ctrl;
      assign unused_ctrl   = ^{clk_i, rst_i, bus.en_i, bus.flush_i, bus.delay_i};
      assign bus.valid_o   = bus.valid_i;
      assign bus.data_o    = bus.data_i;
      assign bus.count_o   = '0;
   end else begin : g_line
      localparam logic [DelW-1:0] MaxDepthW = DelW'(MaxDepth);

      logic [MaxDepth-1:0]  v_q, v_d;
      logic [DataWidth-1:0] d_q [MaxDepth];
      logic [DataWidth-1:0] d_d [MaxDepth];
      logic                 src_v [MaxDepth];
      logic [DataWidth-1:0] src_d [MaxDepth];
      logic [DelW-1:0]      eff_delay;
      logic                 tap_v;
      logic [DataWidth-1:0] tap_d;
      logic [DelW-1:0]      cnt;

      // Each stage's shift source: the input entry for stage 0, the previous stage otherwise.
      for (genvar gi = 0; gi < MaxDepth; gi++) begin : g_src
         if (gi == 0) begin : g_head
            assign src_v[gi] = bus.valid_i;
            assign src_d[gi] = bus.data_i;
         end else begin : g_body
            assign src_v[gi] = v_q[gi-1];
            assign src_d[gi] = d_q[gi-1];
         end
      end

      always_comb begin
         v_d = v_q;
         for (int k = 0; k < MaxDepth; k++) begin
            d_d[k] = d_q[k];
            if (bus.en_i) begin
               v_d[k] = src_v[k];
               d_d[k] = src_d[k];
            end
         end
         // Flush kills every valid bit, including the one being shifted in; data still moves.
         if (bus.flush_i) begin
            v_d = '0;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            v_q <= '0;
            for (int k = 0; k < MaxDepth; k++) begin
               d_q[k] <= '0;
            end
         end else begin
            v_q <= v_d;
            for (int k = 0; k < MaxDepth; k++) begin
               d_q[k] <= d_d[k];
            end
         end
      end

      always_comb begin
         eff_delay = (bus.delay_i > MaxDepthW) ? MaxDepthW : bus.delay_i;
         tap_v     = bus.valid_i;
         tap_d     = bus.data_i;
         cnt       = '0;
         for (int k = 0; k < MaxDepth; k++) begin
            if (DelW'(k + 1) == eff_delay) begin
               tap_v = v_q[k];
               tap_d = d_q[k];
            end
            if ((DelW'(k) < eff_delay) && v_q[k]) begin
               cnt = cnt + DelW'(1);
            end
         end
      end

      assign bus.valid_o = tap_v;
      assign bus.data_o  = tap_d;
      assign bus.count_o = cnt;
   end
endmodule

// File: doc/shift_reg_tap.md
Name: shift_reg_tap

Overview:
- Parametrised successor to the fixed-depth shift register: a stallable, flushable delay line with per-stage valid tracking and a runtime-selectable output tap.
- Used wherever a datapath needs a configurable delay, for example to align side-band data with a variable-latency pipeline.
- Stages advance only when enabled.
- Bubbles are tracked, so the consumer sees valid_o rather than raw register contents.

Parameters:
- DataWidth, 8: width of the data payload in bits; must be >= 1.
- MaxDepth, 4: number of physical stages; 0 is legal and makes the block a pure wire.
- DelW, $clog2(MaxDepth+1) (min 1): derived, not to be overridden; width of delay_i and count_o.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- en_i  input  1  advance enable; when 0, all stages hold.
- flush_i  input  1  clear all stage valid bits.
- delay_i  input  DelW  selected delay in cycles of en_i; values above MaxDepth clamp to MaxDepth.
- valid_i  input  1  input entry valid.
- data_i  input  DataWidth  input payload.
- valid_o  output  1  valid at the selected tap.
- data_o  output  DataWidth  payload at the selected tap.
- count_o  output  DelW  number of valid entries in stages 0..eff_delay-1.

Behaviour:
- State: stages s[0..MaxDepth-1], each holding {v, d}.
- eff_delay = min(delay_i, MaxDepth), computed combinationally every cycle.
- Reset (rst_i=1 at a rising edge): every s[k].v=0 and every s[k].d=0.
  - After reset, for eff_delay>0: valid_o=0, data_o=0, count_o=0.
  - Reset overrides en_i and flush_i.
- Advance (en_i=1, flush_i=0, rst_i=0):
  - s[0] <= {valid_i, data_i}.
  - s[k] <= s[k-1] for k>=1.
  - data_i is captured unconditionally, even when valid_i=0.
- Hold (en_i=0, flush_i=0): all stages keep their value. valid_i and data_i are ignored.
- Flush (flush_i=1, rst_i=0):
  - All s[k].v <= 0.
  - Data follows en_i: shift if en_i=1, hold if en_i=0.
  - An entry presented with valid_i=1 in a flush cycle is discarded.
  - Flush takes priority over en_i for the valid bits.
- Output tap:
  - eff_delay=0: valid_o=valid_i and data_o=data_i, combinationally; count_o=0.
  - eff_delay=d>=1: valid_o=s[d-1].v and data_o=s[d-1].d, driven straight from registers.
  - data_o is defined (last captured data) even when valid_o=0.
- Latency: with en_i held high, an input accepted at edge N appears at the tap d-1 cycles after that edge, i.e. d clock edges of total delay.
  - Each cycle with en_i=0 adds one cycle of latency.
- delay_i change:
  - Takes effect combinationally in the same cycle; the tap simply moves.
  - No state is altered and no entries are duplicated or reconstructed.
  - Entries in stages beyond the new tap are unaffected and reappear if the tap is moved back.
- count_o = popcount(s[0..eff_delay-1].v).
  - Combinational from state and delay_i.
  - Never exceeds eff_delay.
- MaxDepth=0: no registers; valid_o=valid_i, data_o=data_i, count_o=0; en_i, flush_i, rst_i and delay_i are unused.
- No X propagation: all state is reset, and the output mux is fully defined for every delay_i value, including out-of-range values.
- Simultaneous events:
  - rst_i beats flush_i.
  - flush_i beats the valid bit shifted in by en_i.
  - A delay_i change in the same cycle as an advance uses the new eff_delay for the combinational outputs of that cycle.

Test Plan:
1. Reset with MaxDepth=4, DataWidth=8, delay_i=3: hold rst_i=1 for 2 cycles with valid_i=1, data_i=0xAA -> valid_o=0, data_o=0x00, count_o=0 throughout and on the first cycle after release.
2. Streaming, delay_i=3, en_i=1: drive data 0x01,0x02,... with valid_i=1 from edge 0 -> 0x01 with valid_o=1 after edge 2, then one value per cycle; count_o rises 1,2,3 and saturates at 3.
3. Stall and bubble, delay_i=2: send 0x10 (v=1), 0x00 (v=0), 0x11 (v=1), with en_i=0 for 2 cycles between the first two -> tap shows 0x10 v=1, then the bubble (valid_o=0), then 0x11 v=1; count_o is held constant during the stall.
4. Flush with en_i=1 and valid_i=1 (data 0x55) while the line holds 4 valid entries -> next cycle all valid_o=0 and count_o=0 for every delay_i; 0x55 never appears valid.
5. Tap move and clamp: fill 4 entries 0xA0..0xA3 with en_i=0 afterwards; sweep delay_i 0,1,2,3,4,7 -> data_o is data_i, 0xA3, 0xA2, 0xA1, 0xA0, 0xA0; count_o is 0,1,2,3,4,4.
6. MaxDepth=0 build: random valid_i/data_i with random en_i, flush_i and rst_i -> valid_o=valid_i, data_o=data_i, count_o=0 in the same cycle.
